config_shadow_chain: RTL and testbench

Parametrised serial configuration register with a shadow/active split. Configuration bits shift into a shadow chain with a bit counter and trailing even-parity bit. The active (parallel) register updates only on an explicit load strobe, and only when the frame is exactly the right length with correct parity. A readback mode rotates the active contents out serially without disturbing them. The block sits between the chip-level serial config port and the weight/bias consumers, replacing the plain always-live shift chain.

---
 rtl/config_shadow_chain_pkg.sv | 21 ++
 rtl/config_shadow_chain_if.sv | 36 +++
 rtl/config_shadow_chain_shift_frame.sv | 51 +++++
 rtl/config_shadow_chain.sv | 119 +++++++++++
 tb/tb_config_shadow_chain.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/config_shadow_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : config_reg_pkg
// Description : Shared types and sizing helper for the config shadow chain.
// Revision    : 1.0 - initial release
// ============================================================================
package config_reg_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        READBACK = 2'd2
    } cfgState_t;

    // Counter must reach NBITS+2 (overlong marker) without wrapping.
    function automatic int calcCntw(input int nbits);
        return $clog2(nbits + 3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/config_shadow_chain_if.sv
`default_nettype none
// ============================================================================
// Module      : config_shadow_chain_if
// Description : Serial config port and active-register bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface config_shadow_chain_if
    import config_reg_pkg::*;
#(
    parameter int NBITS = 5775
) ();

    localparam int CNTW = calcCntw(NBITS);

    logic             configEn;
    logic             configIn;
    logic             configLoad;
    logic             configRead;
    logic [NBITS-1:0] parallelOut;
    logic             configOut;
    logic             configValid;
    logic             configErr;
    logic [CNTW-1:0]  bitCount;

    modport master (
        output configEn, configIn, configLoad, configRead,
        input  parallelOut, configOut, configValid, configErr, bitCount
    );

    modport slave (
        input  configEn, configIn, configLoad, configRead,
        output parallelOut, configOut, configValid, configErr, bitCount
    );

endinterface
`default_nettype wire

// File: rtl/config_shadow_chain_shift_frame.sv
`default_nettype none
// ============================================================================
// Module      : config_shift_frame
// Description : Shadow shift chain, saturating bit counter and frame check.
// Revision    : 1.0 - initial release
// ============================================================================
module config_shift_frame
    import config_reg_pkg::*;
#(
    parameter int NBITS = 5775
) (
    input  wire logic                       configClk,
    input  wire logic                       configRst,
    input  wire logic                       shiftEn,
    input  wire logic                       clear,
    input  wire logic                       shiftIn,
    output logic [NBITS-1:0]                srData,
    output logic [calcCntw(NBITS)-1:0]      bitCount,
    output logic                            frameGood
);

    localparam int              CNTW        = calcCntw(NBITS);
    localparam logic [CNTW-1:0] c_CNT_FRAME = CNTW'(NBITS + 1);
    localparam logic [CNTW-1:0] c_CNT_SAT   = CNTW'(NBITS + 2);

    logic [NBITS:0]  r_sr;
    logic [CNTW-1:0] r_bitCount;

    always_ff @(posedge configClk) begin
        if (!configRst) begin
            r_sr       <= '0;
            r_bitCount <= '0;
        end else begin
            if (shiftEn) begin
                r_sr <= {r_sr[NBITS-1:0], shiftIn};
            end
            // Commit clears the count but deliberately keeps the shadow data.
            if (clear) begin
                r_bitCount <= '0;
            end else if (shiftEn && (r_bitCount != c_CNT_SAT)) begin
                r_bitCount <= r_bitCount + 1'b1;
            end
        end
    end

    assign srData    = r_sr[NBITS:1];
    assign bitCount  = r_bitCount;
    assign frameGood = (r_bitCount == c_CNT_FRAME) && !(^r_sr);

endmodule
`default_nettype wire

// File: rtl/config_shadow_chain.sv
`default_nettype none
// ============================================================================
// Module      : config_shadow_chain
// Description : Serial config register with shadow/active split and readback.
// Revision    : 1.0 - initial release
// ============================================================================
module config_shadow_chain
    import config_reg_pkg::*;
#(
    parameter int NBITS = 5775
) (
    input  wire logic              configClk,
    input  wire logic              configRst,
    config_shadow_chain_if.slave   cfg
);

    localparam int CNTW = calcCntw(NBITS);

    cfgState_t        r_state;
    cfgState_t        w_stateNext;
    logic [NBITS-1:0] r_active;
    logic [NBITS-1:0] r_rb;
    logic [NBITS-1:0] w_rbNext;
    logic             r_valid;
    logic             r_err;
    logic             r_configOut;
    logic             w_configOutNext;
    logic             w_shiftEn;
    logic             w_commit;
    logic             w_frameGood;
    logic [NBITS-1:0] w_srData;
    logic [CNTW-1:0]  w_bitCount;

    config_shift_frame #(
        .NBITS (NBITS)
    ) u_shiftFrame (
        .configClk (configClk),
        .configRst (configRst),
        .shiftEn   (w_shiftEn),
        .clear     (w_commit),
        .shiftIn   (cfg.configIn),
        .srData    (w_srData),
        .bitCount  (w_bitCount),
        .frameGood (w_frameGood)
    );

    // Load has priority over shifting so the frame is judged pre-edge.
    always_comb begin
        w_stateNext = r_state;
        w_shiftEn   = 1'b0;
        w_commit    = 1'b0;
        w_rbNext    = r_rb;
        case (r_state)
            IDLE: begin
                if (cfg.configLoad) begin
                    w_commit = 1'b1;
                end else if (cfg.configRead) begin
                    w_stateNext = READBACK;
                    w_rbNext    = r_active;
                end else if (cfg.configEn) begin
                    w_stateNext = SHIFT;
                    w_shiftEn   = 1'b1;
                end
            end
            SHIFT: begin
                if (cfg.configLoad) begin
                    w_commit    = 1'b1;
                    w_stateNext = IDLE;
                end else if (cfg.configEn) begin
                    w_shiftEn = 1'b1;
                end
            end
            READBACK: begin
                if (!cfg.configRead) begin
                    w_stateNext = IDLE;
                end else if (cfg.configEn) begin
                    w_rbNext = {r_rb[NBITS-2:0], r_rb[NBITS-1]};
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Serial out is registered from the post-edge view of sr / rb.
    assign w_configOutNext = (w_stateNext == READBACK) ? w_rbNext[NBITS-1]
                           : (w_shiftEn ? w_srData[NBITS-2] : w_srData[NBITS-1]);

    always_ff @(posedge configClk) begin
        if (!configRst) begin
            r_state     <= IDLE;
            r_active    <= '0;
            r_rb        <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_configOut <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_rb        <= w_rbNext;
            r_configOut <= w_configOutNext;
            if (w_commit) begin
                if (w_frameGood) begin
                    r_active <= w_srData;
                    r_valid  <= 1'b1;
                    r_err    <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign cfg.parallelOut = r_active;
    assign cfg.configOut   = r_configOut;
    assign cfg.configValid = r_valid;
    assign cfg.configErr   = r_err;
    assign cfg.bitCount    = w_bitCount;

endmodule
`default_nettype wire

// File: tb/tb_config_shadow_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_config_shadow_chain
// Description : Directed self-checking bench for config_shadow_chain, NBITS=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_config_shadow_chain;

    localparam int NBITS = 8;

    typedef struct {
        logic [15:0] bits;       // frame bits, shifted from bit len-1 down to 0
        int          len;
        logic [3:0]  cntBefore;
        logic [7:0]  po;
        logic        valid;
        logic        err;
    } vec_t;

    logic configClk = 1'b0;
    logic configRst = 1'b0;
    int   errors    = 0;
    int   checks    = 0;
    vec_t vecs[6];

    config_shadow_chain_if #(.NBITS(NBITS)) cfgIf ();

    config_shadow_chain #(.NBITS(NBITS)) dut (
        .configClk (configClk),
        .configRst (configRst),
        .cfg       (cfgIf.slave)
    );

    always #5 configClk = ~configClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge configClk);
        #1;
    endtask

    task automatic shiftBit(input logic b);
        cfgIf.configEn = 1'b1;
        cfgIf.configIn = b;
        step();
        cfgIf.configEn = 1'b0;
        cfgIf.configIn = 1'b0;
    endtask

    task automatic pulseLoad();
        cfgIf.configLoad = 1'b1;
        step();
        cfgIf.configLoad = 1'b0;
    endtask

    task automatic shiftFrame(input logic [15:0] bits, input int len);
        for (int b = len - 1; b >= 0; b--) shiftBit(bits[b]);
    endtask

    initial begin
        cfgIf.configEn   = 1'b0;
        cfgIf.configIn   = 1'b0;
        cfgIf.configLoad = 1'b0;
        cfgIf.configRead = 1'b0;

        //           bits      len cnt  po     v     e
        vecs[0] = '{16'h014A, 9,  4'd9,  8'hA5, 1'b1, 1'b0}; // A5, parity 0
        vecs[1] = '{16'h01FF, 9,  4'd9,  8'hA5, 1'b1, 1'b1}; // FF, bad parity
        vecs[2] = '{16'h0078, 9,  4'd9,  8'h3C, 1'b1, 1'b0}; // 3C clears err
        vecs[3] = '{16'h0016, 5,  4'd5,  8'h3C, 1'b1, 1'b1}; // short
        vecs[4] = '{16'h05A5, 11, 4'd10, 8'h3C, 1'b1, 1'b1}; // overlong, saturates
        vecs[5] = '{16'h014A, 9,  4'd9,  8'hA5, 1'b1, 1'b0}; // A5 again

        repeat (2) step();
        check("rst parallelOut", 32'(cfgIf.parallelOut), 32'h0);
        check("rst configValid", 32'(cfgIf.configValid), 32'h0);
        check("rst configErr",   32'(cfgIf.configErr),   32'h0);
        check("rst bitCount",    32'(cfgIf.bitCount),    32'h0);
        check("rst configOut",   32'(cfgIf.configOut),   32'h0);
        configRst = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            shiftFrame(vecs[i].bits, vecs[i].len);
            check($sformatf("v%0d bitCount pre", i), 32'(cfgIf.bitCount), 32'(vecs[i].cntBefore));
            if (vecs[i].len >= 9)
                check($sformatf("v%0d configOut tail", i), 32'(cfgIf.configOut), 32'(vecs[i].bits[8]));
            pulseLoad();
            check($sformatf("v%0d parallelOut", i), 32'(cfgIf.parallelOut), 32'(vecs[i].po));
            check($sformatf("v%0d configValid", i), 32'(cfgIf.configValid), 32'(vecs[i].valid));
            check($sformatf("v%0d configErr", i),   32'(cfgIf.configErr),   32'(vecs[i].err));
            check($sformatf("v%0d bitCount post", i), 32'(cfgIf.bitCount), 32'h0);
        end

        // Readback of 0xA5: MSB first, wraps to MSB after NBITS rotations.
        begin
            logic [7:0] active;
            active = 8'hA5;
            cfgIf.configRead = 1'b1;
            step();
            for (int k = 0; k <= NBITS; k++) begin
                if (k > 0) begin
                    cfgIf.configEn = 1'b1;
                    step();
                end
                check($sformatf("rb k%0d configOut", k), 32'(cfgIf.configOut),
                      32'(active[(NBITS - 1 - k + NBITS) % NBITS]));
                check($sformatf("rb k%0d parallelOut", k), 32'(cfgIf.parallelOut), 32'hA5);
                check($sformatf("rb k%0d bitCount", k), 32'(cfgIf.bitCount), 32'h0);
            end
            cfgIf.configEn   = 1'b0;
            cfgIf.configRead = 1'b0;
            step();
            check("rb exit bitCount", 32'(cfgIf.bitCount), 32'h0);
        end

        // Collision: 0x5A frame, 10th bit arrives together with load.
        shiftFrame(16'h00B4, 9);
        cfgIf.configEn   = 1'b1;
        cfgIf.configIn   = 1'b1;
        cfgIf.configLoad = 1'b1;
        step();
        cfgIf.configEn   = 1'b0;
        cfgIf.configIn   = 1'b0;
        cfgIf.configLoad = 1'b0;
        check("col parallelOut", 32'(cfgIf.parallelOut), 32'h5A);
        check("col configErr",   32'(cfgIf.configErr),   32'h0);
        check("col bitCount",    32'(cfgIf.bitCount),    32'h0);
        check("col configOut",   32'(cfgIf.configOut),   32'h0);

        // Reset mid-frame, then a fresh good frame 0x96.
        for (int b = 0; b < 4; b++) shiftBit(1'b1);
        configRst = 1'b0;
        step();
        check("mrst parallelOut", 32'(cfgIf.parallelOut), 32'h0);
        check("mrst configValid", 32'(cfgIf.configValid), 32'h0);
        check("mrst configErr",   32'(cfgIf.configErr),   32'h0);
        check("mrst bitCount",    32'(cfgIf.bitCount),    32'h0);
        check("mrst configOut",   32'(cfgIf.configOut),   32'h0);
        configRst = 1'b1;
        step();
        shiftFrame(16'h012C, 9);
        check("post bitCount pre", 32'(cfgIf.bitCount), 32'd9);
        pulseLoad();
        check("post parallelOut", 32'(cfgIf.parallelOut), 32'h96);
        check("post configValid", 32'(cfgIf.configValid), 32'h1);
        check("post configErr",   32'(cfgIf.configErr),   32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
